// File: rtl/uart_pkg.sv
// uart_pkg: constants and state types shared by the UART core files.
//   OS          - oversampling ticks per serial bit
//   PAR_*       - encodings of the par_mode input (2'b11 behaves as none)
//   rx_state_t  - receive engine states
//   tx_state_t  - transmit engine states
//   par_enabled - true when a parity bit is part of the frame
package uart_pkg;

  localparam int OS = 16;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
  } rx_state_t;

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
  } tx_state_t;

  function automatic logic par_enabled(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_core_if.sv
// uart_core_if: byte-wide host port of the UART core.
//   rd/r_data/r_perr/r_ferr/rx_empty - RX FIFO pop side (first-word-fall-through)
//   overrun/clr_ovr                  - sticky dropped-frame flag and its clear
//   wr/w_data/tx_full                - TX FIFO push side
// master = host logic, slave = uart_core.
interface uart_core_if #(
  parameter int DBIT = 8
);
  logic            rd;
  logic [DBIT-1:0] r_data;
  logic            r_perr;
  logic            r_ferr;
  logic            rx_empty;
  logic            overrun;
  logic            clr_ovr;
  logic [DBIT-1:0] w_data;
  logic            wr;
  logic            tx_full;

  modport master (
    output rd, clr_ovr, w_data, wr,
    input  r_data, r_perr, r_ferr, rx_empty, overrun, tx_full
  );

  modport slave (
    input  rd, clr_ovr, w_data, wr,
    output r_data, r_perr, r_ferr, rx_empty, overrun, tx_full
  );
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock first-word-fall-through FIFO of 2^AW entries.
//   clk, reset (sync, active-low)
//   wr, w_data - push; ignored when full unless a pop happens in the same cycle
//   rd, r_data - pop; ignored when empty; r_data shows the head (0 when empty)
//   empty, full
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr,
  input  logic [WIDTH-1:0] w_data,
  input  logic             rd,
  output logic [WIDTH-1:0] r_data,
  output logic             empty,
  output logic             full
);
  logic [WIDTH-1:0] mem [2**AW];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [AW:0]      count;
  logic             do_wr;
  logic             do_rd;

  assign empty = (count == '0);
  assign full  = count[AW];
  // A pop on a full FIFO frees the slot the simultaneous push needs.
  assign do_rd = rd && !empty;
  assign do_wr = wr && (!full || do_rd);
  // Head is forced to 0 while empty so the output is defined out of reset.
  assign r_data = empty ? '0 : mem[rptr];

  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_wr) wptr <= wptr + 1'b1;
      if (do_rd) rptr <= rptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wptr] <= w_data;
  end

endmodule

// File: rtl/uart_core.sv
// uart_core: UART with runtime baud divisor, parity and stop-bit modes,
// and RX/TX FIFOs.
//   clk, reset (sync, active-low)
//   dvsr     - tick rate = clk/(dvsr+1), 16 ticks per bit
//   par_mode - 00 none, 01 even, 10 odd, 11 none; latched per frame
//   stop2    - two stop bits when 1; latched per frame
//   rx, tx   - serial lines (rx asynchronous, tx registered)
//   host     - byte-wide FIFO port (uart_core_if.slave)
module uart_core
  import uart_pkg::*;
#(
  parameter int DBIT    = 8,
  parameter int FIFO_AW = 4,
  parameter int DVSR_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DVSR_W-1:0] dvsr,
  input  logic [1:0]        par_mode,
  input  logic              stop2,
  input  logic              rx,
  output logic              tx,
  uart_core_if.slave        host
);
  localparam logic [3:0] S_LAST   = 4'(OS - 1);
  localparam logic [3:0] S_MID    = 4'(OS / 2 - 1);
  localparam logic [2:0] LAST_BIT = 3'(DBIT - 1);

  // ---------------- baud generator ----------------
  logic [DVSR_W-1:0] baud_cnt;
  logic              tick;

  // >= keeps the counter from running to wrap-around if dvsr shrinks below it.
  assign tick = (baud_cnt >= dvsr);

  always_ff @(posedge clk) begin
    if (!reset) baud_cnt <= '0;
    else        baud_cnt <= tick ? '0 : baud_cnt + 1'b1;
  end

  // ---------------- rx synchroniser ----------------
  logic rx_s1, rx_s2;

  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
    end
  end

  // ---------------- receive engine ----------------
  rx_state_t        rx_state;
  logic [3:0]       rx_s;
  logic [2:0]       rx_n;
  logic [DBIT-1:0]  rx_shift;
  logic             rx_perr, rx_ferr, rx_sb, rx_st2, rx_wr, rx_full;
  logic [1:0]       rx_pm;
  logic [DBIT+1:0]  rx_entry, rx_head;

  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_state <= RX_IDLE;
      rx_s     <= '0;
      rx_n     <= '0;
      rx_shift <= '0;
      rx_perr  <= 1'b0;
      rx_ferr  <= 1'b0;
      rx_sb    <= 1'b0;
      rx_pm    <= PAR_NONE;
      rx_st2   <= 1'b0;
      rx_wr    <= 1'b0;
      rx_entry <= '0;
    end else begin
      rx_wr <= 1'b0;
      case (rx_state)
        RX_IDLE: if (!rx_s2) begin
          rx_state <= RX_START;
          rx_s     <= '0;
          rx_perr  <= 1'b0;
          rx_ferr  <= 1'b0;
          rx_sb    <= 1'b0;
          rx_pm    <= par_mode;
          rx_st2   <= stop2;
        end
        RX_START: if (tick) begin
          // Mid-start re-check rejects glitches shorter than half a bit.
          if (rx_s == S_MID) begin
            rx_s <= '0;
            rx_n <= '0;
            rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
          end else rx_s <= rx_s + 1'b1;
        end
        RX_DATA: if (tick) begin
          if (rx_s == S_LAST) begin
            rx_s     <= '0;
            rx_shift <= {rx_s2, rx_shift[DBIT-1:1]};
            rx_n     <= rx_n + 1'b1;
            if (rx_n == LAST_BIT)
              rx_state <= par_enabled(rx_pm) ? RX_PARITY : RX_STOP;
          end else rx_s <= rx_s + 1'b1;
        end
        RX_PARITY: if (tick) begin
          if (rx_s == S_LAST) begin
            rx_s     <= '0;
            rx_perr  <= rx_s2 != ((^rx_shift) ^ (rx_pm == PAR_ODD));
            rx_state <= RX_STOP;
          end else rx_s <= rx_s + 1'b1;
        end
        RX_STOP: if (tick) begin
          if (rx_s == S_LAST) begin
            rx_s <= '0;
            if (rx_st2 && !rx_sb) begin
              rx_sb <= 1'b1;
              if (!rx_s2) rx_ferr <= 1'b1;
            end else begin
              // Final stop sample folds straight into the entry being written.
              rx_state <= RX_IDLE;
              rx_wr    <= 1'b1;
              rx_entry <= {rx_ferr | ~rx_s2, rx_perr, rx_shift};
            end
          end else rx_s <= rx_s + 1'b1;
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // A clear arriving with a new overrun loses to the overrun.
  logic ovr;
  always_ff @(posedge clk) begin
    if (!reset)                ovr <= 1'b0;
    else if (rx_wr && rx_full) ovr <= 1'b1;
    else if (host.clr_ovr)     ovr <= 1'b0;
  end

  sync_fifo #(.WIDTH(DBIT + 2), .AW(FIFO_AW)) rx_fifo (
    .clk(clk), .reset(reset), .wr(rx_wr), .w_data(rx_entry), .rd(host.rd),
    .r_data(rx_head), .empty(host.rx_empty), .full(rx_full)
  );

  assign host.r_data  = rx_head[DBIT-1:0];
  assign host.r_perr  = rx_head[DBIT];
  assign host.r_ferr  = rx_head[DBIT+1];
  assign host.overrun = ovr;

  // ---------------- transmit engine ----------------
  tx_state_t       tx_state;
  logic [3:0]      tx_s;
  logic [2:0]      tx_n;
  logic [DBIT-1:0] tx_shift, tx_head;
  logic            tx_par, tx_st2, tx_sb, tx_q, tx_empty, tx_pop;
  logic [1:0]      tx_pm;

  assign tx_pop = (tx_state == TX_IDLE) && !tx_empty;
  assign tx     = tx_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      tx_state <= TX_IDLE;
      tx_s     <= '0;
      tx_n     <= '0;
      tx_shift <= '0;
      tx_par   <= 1'b0;
      tx_pm    <= PAR_NONE;
      tx_st2   <= 1'b0;
      tx_sb    <= 1'b0;
      tx_q     <= 1'b1;
    end else begin
      case (tx_state)
        TX_IDLE: if (!tx_empty) begin
          tx_shift <= tx_head;
          tx_par   <= (^tx_head) ^ (par_mode == PAR_ODD);
          tx_pm    <= par_mode;
          tx_st2   <= stop2;
          tx_s     <= '0;
          tx_q     <= 1'b0;
          tx_state <= TX_START;
        end
        TX_START: if (tick) begin
          if (tx_s == S_LAST) begin
            tx_s     <= '0;
            tx_n     <= '0;
            tx_q     <= tx_shift[0];
            tx_state <= TX_DATA;
          end else tx_s <= tx_s + 1'b1;
        end
        TX_DATA: if (tick) begin
          if (tx_s == S_LAST) begin
            tx_s <= '0;
            if (tx_n == LAST_BIT) begin
              tx_sb <= 1'b0;
              if (par_enabled(tx_pm)) begin
                tx_q     <= tx_par;
                tx_state <= TX_PARITY;
              end else begin
                tx_q     <= 1'b1;
                tx_state <= TX_STOP;
              end
            end else begin
              tx_n     <= tx_n + 1'b1;
              tx_shift <= tx_shift >> 1;
              tx_q     <= tx_shift[1];
            end
          end else tx_s <= tx_s + 1'b1;
        end
        TX_PARITY: if (tick) begin
          if (tx_s == S_LAST) begin
            tx_s     <= '0;
            tx_q     <= 1'b1;
            tx_state <= TX_STOP;
          end else tx_s <= tx_s + 1'b1;
        end
        TX_STOP: if (tick) begin
          if (tx_s == S_LAST) begin
            tx_s <= '0;
            if (tx_st2 && !tx_sb) tx_sb <= 1'b1;
            else                  tx_state <= TX_IDLE;
          end else tx_s <= tx_s + 1'b1;
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  sync_fifo #(.WIDTH(DBIT), .AW(FIFO_AW)) tx_fifo (
    .clk(clk), .reset(reset), .wr(host.wr), .w_data(host.w_data), .rd(tx_pop),
    .r_data(tx_head), .empty(tx_empty), .full(host.tx_full)
  );

endmodule

// File: tb/tb_uart_core.sv
// tb_uart_core: table-driven loopback vectors, hand-written error/glitch/
// overrun/reset sequences and randomized frames checked against a queue model.
module tb_uart_core;
  localparam int DBIT = 8;
  localparam int FIFO_AW = 4;
  localparam int DVSR_W = 16;
  localparam int DEPTH = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [DVSR_W-1:0] dvsr = '0;
  logic [1:0]        par_mode = 2'b00;
  logic              stop2 = 1'b0;
  logic              rx_drv = 1'b1;
  logic              loop = 1'b0;
  logic              rx;
  logic              tx;

  assign rx = loop ? tx : rx_drv;

  uart_core_if #(.DBIT(DBIT)) host ();

  uart_core #(.DBIT(DBIT), .FIFO_AW(FIFO_AW), .DVSR_W(DVSR_W)) dut (
    .clk(clk), .reset(reset), .dvsr(dvsr), .par_mode(par_mode),
    .stop2(stop2), .rx(rx), .tx(tx), .host(host)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [9:0] exp_q[$];   // model RX FIFO: {ferr, perr, data}
  logic       model_ovr = 1'b0;
  logic       fb[$];      // serial bits of the frame being built

  typedef struct {
    logic [7:0]  data;
    logic [1:0]  pm;
    logic        s2;
    logic [15:0] dv;
    logic        exp_par;
    logic [7:0]  exp_rx;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic par_on(input logic [1:0] pm);
    return (pm == 2'b01) || (pm == 2'b10);
  endfunction

  // Parity bit that makes the total count of ones even (even mode) or odd.
  function automatic logic calc_par(input logic [7:0] d, input logic [1:0] pm);
    int ones;
    ones = $countones(d);
    if (pm == 2'b10) return (ones % 2) == 0;
    return (ones % 2) == 1;
  endfunction

  function automatic void build_frame(input logic [7:0] d, input logic [1:0] pm,
                                      input logic s2, input logic bad_par);
    fb.delete();
    fb.push_back(1'b0);
    for (int i = 0; i < 8; i++) fb.push_back(d[i]);
    if (par_on(pm)) fb.push_back(calc_par(d, pm) ^ bad_par);
    fb.push_back(1'b1);
    if (s2) fb.push_back(1'b1);
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive one frame on rx; a bad stop bit is held low for 12 of its 16 ticks,
  // followed by an idle bit so the line is clean before the next frame.
  task automatic send_rx(input logic [7:0] d, input logic [1:0] pm, input logic s2,
                         input logic bad_par, input logic bad_stop);
    int bc;
    int stop_idx;
    bc = 16 * (dvsr + 1);
    stop_idx = par_on(pm) ? 10 : 9;
    par_mode = pm;
    stop2 = s2;
    build_frame(d, pm, s2, bad_par);
    for (int i = 0; i < fb.size(); i++) begin
      if (i == stop_idx && bad_stop) begin
        rx_drv = 1'b0;
        cycles(12 * (dvsr + 1));
        rx_drv = 1'b1;
        cycles(4 * (dvsr + 1));
      end else begin
        rx_drv = fb[i];
        cycles(bc);
      end
    end
    rx_drv = 1'b1;
    if (bad_stop) cycles(bc);
    cycles(4);
    if (exp_q.size() < DEPTH) exp_q.push_back({bad_stop, bad_par & par_on(pm), d});
    else model_ovr = 1'b1;
  endtask

  task automatic pop_check(input string tag);
    logic [9:0] e;
    @(negedge clk);
    e = exp_q.pop_front();
    chk({tag, "_rx_empty"}, host.rx_empty, 1'b0);
    chk({tag, "_data"}, host.r_data, e[7:0]);
    chk({tag, "_perr"}, host.r_perr, e[8]);
    chk({tag, "_ferr"}, host.r_ferr, e[9]);
    @(posedge clk);
    #1 host.rd = 1'b1;
    @(posedge clk);
    #1 host.rd = 1'b0;
  endtask

  // Write one byte, check start latency, sample the tx frame mid-bit, then
  // check the looped-back RX entry.
  task automatic tx_vec(input vec_t v);
    int bc;
    int nb;
    logic pe;
    logic [15:0] exp_w;
    logic [15:0] act_w;
    dvsr = v.dv;
    par_mode = v.pm;
    stop2 = v.s2;
    cycles(2);
    bc = 16 * (v.dv + 1);
    pe = par_on(v.pm);
    nb = 10 + int'(pe) + int'(v.s2);
    exp_w = '1;
    exp_w[0] = 1'b0;
    exp_w[8:1] = v.data;
    if (pe) exp_w[9] = v.exp_par;
    act_w = '1;
    host.w_data = v.data;
    host.wr = 1'b1;
    @(posedge clk);
    #1 host.wr = 1'b0;
    @(negedge clk);
    chk("tx_idle_after_wr", tx, 1'b1);
    @(negedge clk);
    chk("tx_start_latency", tx, 1'b0);
    repeat (bc / 2) @(negedge clk);
    for (int k = 0; k < nb; k++) begin
      act_w[k] = tx;
      if (k < nb - 1) repeat (bc) @(negedge clk);
    end
    chk("tx_frame", act_w, exp_w);
    cycles(bc + 8);
    exp_q.push_back({2'b00, v.exp_rx});
    pop_check("loop");
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    host.rd = 1'b0;
    host.wr = 1'b0;
    host.w_data = '0;
    host.clr_ovr = 1'b0;

    vecs[0] = '{8'hA5, 2'b00, 1'b0, 16'd0, 1'b0, 8'hA5};
    vecs[1] = '{8'h07, 2'b01, 1'b0, 16'd0, 1'b1, 8'h07};
    vecs[2] = '{8'h07, 2'b10, 1'b0, 16'd0, 1'b0, 8'h07};
    vecs[3] = '{8'h3C, 2'b00, 1'b1, 16'd0, 1'b0, 8'h3C};
    vecs[4] = '{8'hFF, 2'b10, 1'b1, 16'd0, 1'b1, 8'hFF};
    vecs[5] = '{8'h00, 2'b01, 1'b0, 16'd0, 1'b0, 8'h00};
    vecs[6] = '{8'h5A, 2'b11, 1'b0, 16'd0, 1'b0, 8'h5A};
    vecs[7] = '{8'h81, 2'b01, 1'b1, 16'd2, 1'b0, 8'h81};

    // reset state
    cycles(3);
    @(negedge clk);
    chk("rst_tx", tx, 1'b1);
    chk("rst_rx_empty", host.rx_empty, 1'b1);
    chk("rst_tx_full", host.tx_full, 1'b0);
    chk("rst_overrun", host.overrun, 1'b0);
    chk("rst_r_data", host.r_data, 8'h00);
    chk("rst_r_perr", host.r_perr, 1'b0);
    chk("rst_r_ferr", host.r_ferr, 1'b0);
    @(posedge clk);
    #1 reset = 1'b1;
    cycles(5);

    // loopback table
    loop = 1'b1;
    for (int i = 0; i < 8; i++) tx_vec(vecs[i]);
    dvsr = '0;
    loop = 1'b0;
    cycles(20);

    // injected parity error, data intact
    send_rx(8'h07, 2'b01, 1'b0, 1'b1, 1'b0);
    pop_check("par_err");

    // framing error, then a clean frame
    send_rx(8'h96, 2'b00, 1'b0, 1'b0, 1'b1);
    pop_check("frm_err");
    send_rx(8'h3C, 2'b00, 1'b0, 1'b0, 1'b0);
    pop_check("frm_clean");

    // short glitch on rx is rejected; receiver still works afterwards
    rx_drv = 1'b0;
    cycles(4);
    rx_drv = 1'b1;
    cycles(40);
    @(negedge clk);
    chk("glitch_rx_empty", host.rx_empty, 1'b1);
    send_rx(8'h5A, 2'b00, 1'b0, 1'b0, 1'b0);
    pop_check("after_glitch");

    // random loopback burst
    par_mode = 2'($urandom_range(0, 3));
    stop2 = 1'($urandom_range(0, 1));
    loop = 1'b1;
    cycles(2);
    for (int i = 0; i < 10; i++) begin
      logic [7:0] d;
      d = 8'($urandom);
      host.w_data = d;
      host.wr = 1'b1;
      exp_q.push_back({2'b00, d});
      @(posedge clk);
      #1;
    end
    host.wr = 1'b0;
    cycles(2300);
    @(negedge clk);
    chk("burst_tx_idle", tx, 1'b1);
    for (int i = 0; i < 10; i++) pop_check("burst");
    loop = 1'b0;
    cycles(4);

    // random frames with random errors, 17 frames without reading -> overrun
    for (int i = 0; i < 17; i++)
      send_rx(8'($urandom), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0));
    @(negedge clk);
    chk("overrun_set", host.overrun, model_ovr);
    while (exp_q.size() > 0) pop_check("ovr_fifo");
    @(negedge clk);
    chk("ovr_drained", host.rx_empty, 1'b1);
    chk("overrun_sticky", host.overrun, 1'b1);
    @(posedge clk);
    #1 host.clr_ovr = 1'b1;
    cycles(1);
    host.clr_ovr = 1'b0;
    @(negedge clk);
    chk("overrun_cleared", host.overrun, 1'b0);

    // reset in the middle of a transmit frame
    dvsr = '0;
    par_mode = 2'b00;
    stop2 = 1'b0;
    loop = 1'b1;
    cycles(2);
    for (int i = 0; i < 17; i++) begin
      host.w_data = 8'($urandom);
      host.wr = 1'b1;
      @(posedge clk);
      #1;
    end
    host.wr = 1'b0;
    @(negedge clk);
    chk("tx_full", host.tx_full, 1'b1);
    cycles(33);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_tx", tx, 1'b1);
    chk("mid_rst_tx_full", host.tx_full, 1'b0);
    chk("mid_rst_rx_empty", host.rx_empty, 1'b0 ^ 1'b1);
    #1 reset = 1'b1;
    begin
      int zeros;
      zeros = 0;
      repeat (400) begin
        @(negedge clk);
        if (tx !== 1'b1) zeros++;
      end
      chk("no_residual_tx", zeros, 0);
    end
    chk("no_residual_rx", host.rx_empty, 1'b1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
